vga_chain_source: RTL and testbench
===================================

// Module: vga_chain_source
// PURPOSE
//  Head of the VGA pixel chain. Generates 640x480@60 timing from the system clock
//  and launches the per-pixel record (pxl_x, pxl_y, sync, colour, en) into vga_chain_out.
//  Every drawing stage (stars, ships, asteroids, text) consumes the record, overlays it
//  and forwards it. This block is the originator that all those stages depend on.
// PARAMETERS
//  WIDTH    640  visible pixels per line
//  HEIGHT   480  visible lines per frame
//  H_FP     16   horizontal front porch, pixels
//  H_SYNC   96   horizontal sync width, pixels
//  H_BP     48   horizontal back porch, pixels
//  V_FP     10   vertical front porch, lines
//  V_SYNC   2    vertical sync width, lines
//  V_BP     33   vertical back porch, lines
//  CLK_DIV  2    clk cycles per pixel; must be >=1
//  BG_RGB   12'h000  background {red,green,blue} driven on visible pixels
// PORTS
//  clk            in   1    system clock (50 MHz)
//  reset          in   1    asynchronous reset, active-high
//  pause          in   1    1 = freeze counters at current pixel; strobe still counts
//  vga_chain_out  out  vga.out  record t: pxl_x, pxl_y, red, green, blue, en, hsync, vsync, active
//  pxl_stb        out  1    1-clk pulse; vga_chain_out.t updated in this cycle
//  frame_start    out  1    1-clk pulse, coincident with pxl_stb, when t is at (0,0)
// BEHAVIOUR
//  - H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP (800). V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP (525).
//    Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL).
//  - Reset values: divider=0, hcnt=0, vcnt=0, pxl_stb=0, frame_start=0,
//    t='0 with hsync=1 and vsync=1 (syncs idle high).
//  - Divider counts 0..CLK_DIV-1 and wraps. Strobe condition: divider==CLK_DIV-1.
//    With CLK_DIV=1 the strobe is true every clk.
//  - On strobe, registered with 1-clk latency:
//    - t.pxl_x <= hcnt, t.pxl_y <= vcnt
//    - t.active <= (hcnt<WIDTH)&&(vcnt<HEIGHT)
//    - t.hsync <= !(hcnt in [WIDTH+H_FP, WIDTH+H_FP+H_SYNC-1])
//    - t.vsync <= !(vcnt in [HEIGHT+V_FP, HEIGHT+V_FP+V_SYNC-1])
//    - {red,green,blue} <= active ? BG_RGB : 12'h000
//    - t.en <= 0 (no object drawn at the source)
//    - pxl_stb <= 1; frame_start <= (hcnt==0 && vcnt==0)
//  - Between strobes: t holds its value; pxl_stb=0, frame_start=0.
//  - Counter advance on strobe while pause=0:
//    - hcnt == H_TOTAL-1 -> hcnt=0 and vcnt increments.
//    - vcnt == V_TOTAL-1 at that wrap -> vcnt=0.
//  - Counter advance with pause=1: counters hold, and the same pixel is re-emitted on
//    every strobe. frame_start re-pulses if the pause lands on (0,0).
//  - During blanking, pxl_x/pxl_y carry the raw counter values (up to 799/524).
//    Downstream stages must gate on t.active.
//  - Reset asserted mid-frame clears state immediately. After deassertion, the first
//    strobe (CLK_DIV clks later) emits (0,0) with frame_start=1.
// TESTING
//  1 Reset release, CLK_DIV=2 -> pxl_stb on clk 2,4,6...; the first t is (0,0) with
//    frame_start=1, active=1, hsync=1, vsync=1.
//  2 Run one line -> hsync=0 exactly for pxl_x 656..751 (96 strobes). At pxl_x 799 the
//    next strobe gives pxl_x=0 and pxl_y+1.
//  3 Run one frame -> vsync=0 for pxl_y 490..491. Exactly 420000 strobes elapse
//    between frame_start pulses.
//  4 BG_RGB=12'h124 -> rgb=1,2,4 while active; at pxl_x=640 and at pxl_y=480, rgb=0 and en=0.
//  5 pause=1 at (100,50) for 10 strobes -> t stays (100,50); release -> next t is (101,50).
//  6 Assert reset at (300,200), then release -> outputs at reset values; the first
//    strobe emits (0,0) with frame_start=1. Repeat with CLK_DIV=1 -> pxl_stb every clk.

Source files
------------

// File: rtl/vga_chain_source_if.sv
// Per-pixel record carried down the VGA drawing chain.
// The source drives t; every overlay stage reads it and forwards its own copy.
interface vga_chain_source_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  typedef struct packed {
    logic [XW-1:0] pxl_x;
    logic [YW-1:0] pxl_y;
    logic [3:0]    red;
    logic [3:0]    green;
    logic [3:0]    blue;
    logic          en;
    logic          hsync;
    logic          vsync;
    logic          active;
  } vga_t;

  vga_t t;

  modport master (output t);
  modport slave  (input  t);
endinterface

// File: rtl/vga_chain_source.sv
// Head of the VGA pixel chain: 640x480@60 timing generator that launches the
// per-pixel record on every pixel strobe.
module vga_chain_source #(
  parameter int          WIDTH   = 640,
  parameter int          HEIGHT  = 480,
  parameter int          H_FP    = 16,
  parameter int          H_SYNC  = 96,
  parameter int          H_BP    = 48,
  parameter int          V_FP    = 10,
  parameter int          V_SYNC  = 2,
  parameter int          V_BP    = 33,
  parameter int          CLK_DIV = 2,
  parameter logic [11:0] BG_RGB  = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  vga_chain_source_if.master vga_chain_out,
  output logic               pxl_stb,
  output logic               frame_start
);
  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_VIS     = HW'(WIDTH);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(WIDTH + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(WIDTH + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS     = VW'(HEIGHT);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(HEIGHT + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(HEIGHT + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [VW-1:0] vcnt_reg, vcnt_next;
  logic [HW-1:0] pxl_x_reg;
  logic [VW-1:0] pxl_y_reg;
  logic [11:0]   rgb_reg, rgb_next;
  logic          hsync_reg, vsync_reg, active_reg;
  logic          pxl_stb_reg, frame_start_reg;
  logic          stb, active_next, hsync_next, vsync_next, origin;

  always_comb begin
    stb         = (div_reg == DIV_LAST);
    active_next = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);
    hsync_next  = !((hcnt_reg >= H_SYNC_LO) && (hcnt_reg <= H_SYNC_HI));
    vsync_next  = !((vcnt_reg >= V_SYNC_LO) && (vcnt_reg <= V_SYNC_HI));
    rgb_next    = active_next ? BG_RGB : 12'h000;
    origin      = (hcnt_reg == '0) && (vcnt_reg == '0);
    hcnt_next   = hcnt_reg;
    vcnt_next   = vcnt_reg;
    // Pause freezes the raster position so the same pixel is re-emitted.
    if (stb && !pause) begin
      if (hcnt_reg == H_LAST) begin
        hcnt_next = '0;
        vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + VW'(1);
      end else begin
        hcnt_next = hcnt_reg + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg         <= '0;
      hcnt_reg        <= '0;
      vcnt_reg        <= '0;
      pxl_x_reg       <= '0;
      pxl_y_reg       <= '0;
      rgb_reg         <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      active_reg      <= 1'b0;
      pxl_stb_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= stb ? '0 : div_reg + DW'(1);
      hcnt_reg        <= hcnt_next;
      vcnt_reg        <= vcnt_next;
      pxl_stb_reg     <= stb;
      frame_start_reg <= stb && origin;
      if (stb) begin
        pxl_x_reg  <= hcnt_reg;
        pxl_y_reg  <= vcnt_reg;
        rgb_reg    <= rgb_next;
        hsync_reg  <= hsync_next;
        vsync_reg  <= vsync_next;
        active_reg <= active_next;
      end
    end
  end

  // Nothing is drawn at the source, so en is constant low.
  assign vga_chain_out.t = {pxl_x_reg, pxl_y_reg, rgb_reg, 1'b0,
                            hsync_reg, vsync_reg, active_reg};
  assign pxl_stb         = pxl_stb_reg;
  assign frame_start     = frame_start_reg;
endmodule

// File: tb/tb_vga_chain_source.sv
// Directed bench for vga_chain_source: full-size timing at CLK_DIV 2 and 1,
// plus a scaled-down raster so whole frames fit in a short run.
module tb_vga_chain_source;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a = 1'b1, reset_b = 1'b1, reset_c = 1'b1;
  logic pause_a = 1'b0, pause_b = 1'b0, pause_c = 1'b0;
  logic stb_a, fs_a, stb_b, fs_b, stb_c, fs_c;
  int   checks = 0;
  int   failures = 0;

  vga_chain_source_if #(.XW(10), .YW(10)) if_a ();
  vga_chain_source_if #(.XW(10), .YW(10)) if_b ();
  vga_chain_source_if #(.XW(4),  .YW(4))  if_c ();

  vga_chain_source #(.CLK_DIV(2), .BG_RGB(12'h124)) dut_a (
    .clk(clk), .reset(reset_a), .pause(pause_a), .vga_chain_out(if_a.master),
    .pxl_stb(stb_a), .frame_start(fs_a));

  vga_chain_source #(.CLK_DIV(1), .BG_RGB(12'h000)) dut_b (
    .clk(clk), .reset(reset_b), .pause(pause_b), .vga_chain_out(if_b.master),
    .pxl_stb(stb_b), .frame_start(fs_b));

  // 15x10 raster: hsync low x 10..12, vsync low y 7..8, 150 strobes per frame.
  vga_chain_source #(.WIDTH(8), .HEIGHT(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1), .BG_RGB(12'h124)) dut_c (
    .clk(clk), .reset(reset_c), .pause(pause_c), .vga_chain_out(if_c.master),
    .pxl_stb(stb_c), .frame_start(fs_c));

  task automatic next_stb(input int d, output bit to);
    to = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((d == 0 && stb_a === 1'b1) || (d == 1 && stb_b === 1'b1) || (d == 2 && stb_c === 1'b1)) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      failures++;
      $display("FAIL stb_timeout: dut %0d gave no pxl_stb within 8 clks, required one", d);
    end
  endtask

  task automatic test_reset;
    logic [5:0] seen;
    int fx, fy, x2;
    logic ffs, fact, fen, fs2;
    logic [1:0] fsync;
    logic [11:0] frgb;
    seen = '0; fx = -1; fy = -1; x2 = -1; ffs = 0; fact = 0; fen = 1; fs2 = 1; fsync = 0; frgb = 0;
    @(negedge clk);
    checks++;
    if ({stb_a, fs_a} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses: stb/fs=%b required 00", {stb_a, fs_a});
    end
    checks++;
    if ({if_a.t.pxl_x, if_a.t.pxl_y, if_a.t.red, if_a.t.green, if_a.t.blue, if_a.t.en, if_a.t.active} !== 34'd0) begin
      failures++; $display("FAIL reset_record: x=%0d y=%0d act=%b required all zero", if_a.t.pxl_x, if_a.t.pxl_y, if_a.t.active);
    end
    checks++;
    if ({if_a.t.hsync, if_a.t.vsync} !== 2'b11) begin
      failures++; $display("FAIL reset_syncs: hs/vs=%b required 11", {if_a.t.hsync, if_a.t.vsync});
    end
    reset_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen[k] = stb_a;
      if (k == 1) begin
        fx = int'(if_a.t.pxl_x); fy = int'(if_a.t.pxl_y); ffs = fs_a; fact = if_a.t.active;
        fen = if_a.t.en; fsync = {if_a.t.hsync, if_a.t.vsync};
        frgb = {if_a.t.red, if_a.t.green, if_a.t.blue};
      end
      if (k == 3) begin
        x2 = int'(if_a.t.pxl_x); fs2 = fs_a;
      end
    end
    checks++;
    if (seen !== 6'b101010) begin
      failures++; $display("FAIL stb_cadence_div2: clk1..6 pattern=%b required 101010", seen);
    end
    checks++;
    if (fx !== 0 || fy !== 0 || ffs !== 1'b1) begin
      failures++; $display("FAIL first_pixel: (%0d,%0d) fs=%b required (0,0) fs=1", fx, fy, ffs);
    end
    checks++;
    if (fact !== 1'b1 || fsync !== 2'b11 || frgb !== 12'h124 || fen !== 1'b0) begin
      failures++; $display("FAIL first_attrs: act=%b hs/vs=%b rgb=%h en=%b required 1 11 124 0", fact, fsync, frgb, fen);
    end
    checks++;
    if (x2 !== 1 || fs2 !== 1'b0) begin
      failures++; $display("FAIL second_pixel: x=%0d fs=%b required 1 0", x2, fs2);
    end
    $display("test_reset done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_line;
    int ex, ey, hs_low, hs_bad, act_bad, pos_bad, vs_bad;
    bit to;
    logic exp_act;
    ex = 2; ey = 0; hs_low = 0; hs_bad = 0; act_bad = 0; pos_bad = 0; vs_bad = 0;
    for (int n = 0; n < 798; n++) begin
      next_stb(0, to);
      if (to) break;
      ex++;
      if (ex == 800) begin ex = 0; ey++; end
      if (int'(if_a.t.pxl_x) !== ex || int'(if_a.t.pxl_y) !== ey) pos_bad++;
      if (if_a.t.hsync === 1'b0) hs_low++;
      if (if_a.t.hsync !== ((ex >= 656 && ex <= 751) ? 1'b0 : 1'b1)) hs_bad++;
      if (if_a.t.vsync !== 1'b1) vs_bad++;
      exp_act = (ex < 640) ? 1'b1 : 1'b0;
      if (if_a.t.active !== exp_act || if_a.t.en !== 1'b0 ||
          {if_a.t.red, if_a.t.green, if_a.t.blue} !== (exp_act ? 12'h124 : 12'h000)) act_bad++;
      if (ex == 640) begin
        checks++;
        if ({if_a.t.red, if_a.t.green, if_a.t.blue, if_a.t.en, if_a.t.active} !== 14'd0) begin
          failures++; $display("FAIL edge_x640: rgb=%h en=%b act=%b required 000 0 0",
                               {if_a.t.red, if_a.t.green, if_a.t.blue}, if_a.t.en, if_a.t.active);
        end
      end
    end
    checks++;
    if (hs_low !== 96 || hs_bad !== 0) begin
      failures++; $display("FAIL hsync_window: low=%0d wrong=%0d required 96 0", hs_low, hs_bad);
    end
    checks++;
    if (pos_bad !== 0 || vs_bad !== 0 || act_bad !== 0) begin
      failures++; $display("FAIL line_scan: pos_err=%0d vsync_err=%0d active_err=%0d required 0 0 0", pos_bad, vs_bad, act_bad);
    end
    checks++;
    if (if_a.t.pxl_x !== 10'd0 || if_a.t.pxl_y !== 10'd1 || fs_a !== 1'b0) begin
      failures++; $display("FAIL line_wrap: (%0d,%0d) fs=%b required (0,1) 0", if_a.t.pxl_x, if_a.t.pxl_y, fs_a);
    end
    $display("test_line done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_pause;
    int held_bad;
    bit to;
    held_bad = 0;
    for (int n = 0; n < 99; n++) begin
      next_stb(0, to);
      if (to) break;
    end
    checks++;
    if (if_a.t.pxl_x !== 10'd99 || if_a.t.pxl_y !== 10'd1) begin
      failures++; $display("FAIL pause_setup: (%0d,%0d) required (99,1)", if_a.t.pxl_x, if_a.t.pxl_y);
    end
    pause_a = 1'b1;
    for (int n = 0; n < 9; n++) begin
      next_stb(0, to);
      if (if_a.t.pxl_x !== 10'd100 || if_a.t.pxl_y !== 10'd1 || fs_a !== 1'b0) held_bad++;
    end
    pause_a = 1'b0;
    next_stb(0, to);
    checks++;
    if (held_bad !== 0 || if_a.t.pxl_x !== 10'd100 || if_a.t.pxl_y !== 10'd1) begin
      failures++; $display("FAIL pause_hold: wrong=%0d last=(%0d,%0d) required 0 (100,1)", held_bad, if_a.t.pxl_x, if_a.t.pxl_y);
    end
    next_stb(0, to);
    checks++;
    if (if_a.t.pxl_x !== 10'd101 || if_a.t.pxl_y !== 10'd1) begin
      failures++; $display("FAIL pause_release: (%0d,%0d) required (101,1)", if_a.t.pxl_x, if_a.t.pxl_y);
    end
    $display("test_pause done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid;
    bit to;
    logic [1:0] seen;
    for (int n = 0; n < 199; n++) begin
      next_stb(0, to);
      if (to) break;
    end
    checks++;
    if (if_a.t.pxl_x !== 10'd300 || if_a.t.pxl_y !== 10'd1) begin
      failures++; $display("FAIL midreset_setup: (%0d,%0d) required (300,1)", if_a.t.pxl_x, if_a.t.pxl_y);
    end
    reset_a = 1'b1;
    #1;
    checks++;
    if ({stb_a, fs_a, if_a.t.pxl_x, if_a.t.pxl_y, if_a.t.active} !== 23'd0 ||
        {if_a.t.hsync, if_a.t.vsync} !== 2'b11) begin
      failures++; $display("FAIL midreset_clear: stb=%b x=%0d y=%0d hs/vs=%b required 0 0 0 11",
                           stb_a, if_a.t.pxl_x, if_a.t.pxl_y, {if_a.t.hsync, if_a.t.vsync});
    end
    repeat (2) @(negedge clk);
    reset_a = 1'b0;
    seen = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      seen[k] = stb_a;
    end
    checks++;
    if (seen !== 2'b10 || if_a.t.pxl_x !== 10'd0 || if_a.t.pxl_y !== 10'd0 || fs_a !== 1'b1) begin
      failures++; $display("FAIL midreset_restart: stb=%b (%0d,%0d) fs=%b required 10 (0,0) 1",
                           seen, if_a.t.pxl_x, if_a.t.pxl_y, fs_a);
    end
    $display("test_reset_mid done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clkdiv1;
    int bad;
    bit to;
    bad = 0;
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    checks++;
    if (stb_b !== 1'b1 || fs_b !== 1'b1 || if_b.t.pxl_x !== 10'd0 || if_b.t.pxl_y !== 10'd0 ||
        if_b.t.active !== 1'b1 || {if_b.t.red, if_b.t.green, if_b.t.blue} !== 12'h000) begin
      failures++; $display("FAIL div1_first: stb=%b fs=%b (%0d,%0d) act=%b required 1 1 (0,0) 1",
                           stb_b, fs_b, if_b.t.pxl_x, if_b.t.pxl_y, if_b.t.active);
    end
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      if (stb_b !== 1'b1 || fs_b !== 1'b0 || int'(if_b.t.pxl_x) !== k) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL div1_cadence: %0d of 5 clks wrong, required 0", bad);
    end
    for (int n = 0; n < 295; n++) begin
      next_stb(1, to);
      if (to) break;
    end
    checks++;
    if (if_b.t.pxl_x !== 10'd300 || if_b.t.pxl_y !== 10'd0) begin
      failures++; $display("FAIL div1_setup: (%0d,%0d) required (300,0)", if_b.t.pxl_x, if_b.t.pxl_y);
    end
    reset_b = 1'b1;
    #1;
    checks++;
    if ({stb_b, fs_b, if_b.t.pxl_x} !== 12'd0 || {if_b.t.hsync, if_b.t.vsync} !== 2'b11) begin
      failures++; $display("FAIL div1_reset: stb=%b x=%0d hs/vs=%b required 0 0 11", stb_b, if_b.t.pxl_x, {if_b.t.hsync, if_b.t.vsync});
    end
    @(negedge clk);
    reset_b = 1'b0;
    @(negedge clk);
    checks++;
    if (stb_b !== 1'b1 || fs_b !== 1'b1 || if_b.t.pxl_x !== 10'd0 || if_b.t.pxl_y !== 10'd0) begin
      failures++; $display("FAIL div1_restart: stb=%b fs=%b (%0d,%0d) required 1 1 (0,0)", stb_b, fs_b, if_b.t.pxl_x, if_b.t.pxl_y);
    end
    $display("test_clkdiv1 done: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_frame;
    int ex, ey, n, vs_low, vs_bad, pos_bad;
    bit to;
    ex = 0; ey = 0; n = 0; vs_low = 0; vs_bad = 0; pos_bad = 0;
    @(negedge clk);
    reset_c = 1'b0;
    next_stb(2, to);
    checks++;
    if (fs_c !== 1'b1 || if_c.t.pxl_x !== 4'd0 || if_c.t.pxl_y !== 4'd0) begin
      failures++; $display("FAIL frame_first: fs=%b (%0d,%0d) required 1 (0,0)", fs_c, if_c.t.pxl_x, if_c.t.pxl_y);
    end
    for (int i = 0; i < 200; i++) begin
      next_stb(2, to);
      if (to) break;
      n++;
      ex++;
      if (ex == 15) begin ex = 0; ey = (ey == 9) ? 0 : ey + 1; end
      if (int'(if_c.t.pxl_x) !== ex || int'(if_c.t.pxl_y) !== ey) pos_bad++;
      if (if_c.t.vsync === 1'b0) vs_low++;
      if (if_c.t.vsync !== ((ey >= 7 && ey <= 8) ? 1'b0 : 1'b1)) vs_bad++;
      if (ex == 3 && ey == 2) begin
        checks++;
        if ({if_c.t.red, if_c.t.green, if_c.t.blue} !== 12'h124 || if_c.t.active !== 1'b1) begin
          failures++; $display("FAIL frame_bg: rgb=%h act=%b required 124 1", {if_c.t.red, if_c.t.green, if_c.t.blue}, if_c.t.active);
        end
      end
      if ((ex == 8 && ey == 0) || (ex == 0 && ey == 6)) begin
        checks++;
        if ({if_c.t.red, if_c.t.green, if_c.t.blue, if_c.t.en, if_c.t.active} !== 14'd0) begin
          failures++; $display("FAIL frame_edge(%0d,%0d): rgb=%h en=%b act=%b required 000 0 0", ex, ey,
                               {if_c.t.red, if_c.t.green, if_c.t.blue}, if_c.t.en, if_c.t.active);
        end
      end
      if (fs_c === 1'b1) break;
    end
    checks++;
    if (n !== 150 || ex !== 0 || ey !== 0) begin
      failures++; $display("FAIL frame_period: %0d strobes ending at (%0d,%0d) required 150 (0,0)", n, ex, ey);
    end
    checks++;
    if (vs_low !== 30 || vs_bad !== 0 || pos_bad !== 0) begin
      failures++; $display("FAIL frame_vsync: low=%0d vs_err=%0d pos_err=%0d required 30 0 0", vs_low, vs_bad, pos_bad);
    end
    $display("test_frame done: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    test_line;
    test_pause;
    test_reset_mid;
    test_clkdiv1;
    test_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
